// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the ALU issue/writeback stage.
package alu_issue_pkg;

  localparam int DW  = 8;
  localparam int FSW = 2;
  localparam int FW  = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

endpackage

// File: rtl/alu_regfile.sv
// Register file: two operand read ports, a debug read port, and a shared write
// path where ALU writeback beats a host load to the same address.
module alu_regfile
  import alu_issue_pkg::*;
#(
  parameter int DW   = alu_issue_pkg::DW,
  parameter int NREG = 4,
  parameter int AW   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rs1_addr_i,
  input  logic [AW-1:0] rs2_addr_i,
  output logic [DW-1:0] rs1_data_o,
  output logic [DW-1:0] rs2_data_o,
  input  logic [AW-1:0] dbg_addr_i,
  output logic [DW-1:0] dbg_data_o,
  input  logic          wb_en_i,
  input  logic [AW-1:0] wb_addr_i,
  input  logic [DW-1:0] wb_data_i,
  input  logic          ld_valid_i,
  input  logic [AW-1:0] ld_addr_i,
  input  logic [DW-1:0] ld_data_i,
  output logic          ld_ack_o
);

  logic [DW-1:0] rf_q [NREG];
  logic          ld_ok;

  // A load is only refused when it collides with the writeback address.
  assign ld_ok    = ld_valid_i && !(wb_en_i && (ld_addr_i == wb_addr_i));
  assign ld_ack_o = ld_ok;

  assign rs1_data_o = rf_q[rs1_addr_i];
  assign rs2_data_o = rf_q[rs2_addr_i];
  assign dbg_data_o = rf_q[dbg_addr_i];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wb_en_i && (wb_addr_i == AW'(i))) begin
          rf_q[i] <= wb_data_i;
        end else if (ld_ok && (ld_addr_i == AW'(i))) begin
          rf_q[i] <= ld_data_i;
        end
      end
    end
  end

endmodule

// File: rtl/alu_issue_unit.sv
// Issue/writeback stage around a combinational 8-bit ALU.
// Optional ALU_IMM_EN adds an immediate operand-B source (in_imm/in_use_imm).
module alu_issue_unit
  import alu_issue_pkg::*;
#(
  parameter int DW   = alu_issue_pkg::DW,
  parameter int NREG = 4,
  parameter int AW   = 2,
  parameter int FW   = alu_issue_pkg::FW,
  parameter int CW   = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [FSW-1:0] in_fs,
  input  logic [AW-1:0]  in_rd,
  input  logic [AW-1:0]  in_rs1,
  input  logic [AW-1:0]  in_rs2,
`ifdef ALU_IMM_EN
  input  logic [DW-1:0]  in_imm,
  input  logic           in_use_imm,
`endif
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [FSW-1:0] alu_fs,
  input  logic [DW-1:0]  alu_y,
  input  logic [FW-1:0]  alu_flag,
  input  logic           ld_valid,
  input  logic [AW-1:0]  ld_addr,
  input  logic [DW-1:0]  ld_data,
  output logic           ld_ack,
  input  logic [AW-1:0]  rd_addr,
  output logic [DW-1:0]  rd_data,
  output logic [FW-1:0]  flag_q,
  output logic           done,
  output logic [CW-1:0]  retired
);

  state_e         state_q, state_d;
  logic [AW-1:0]  rd_q;
  logic [DW-1:0]  alu_a_q, alu_b_q;
  logic [FSW-1:0] alu_fs_q;
  logic [FW-1:0]  flag_reg_q;
  logic           done_q;
  logic [CW-1:0]  retired_q;

  logic           accept;
  logic           wb_en;
  logic [DW-1:0]  rs1_data, rs2_data, opb;

  alu_regfile #(
    .DW   (DW),
    .NREG (NREG),
    .AW   (AW)
  ) u_rf (
    .clk        (clk),
    .rst        (rst),
    .rs1_addr_i (in_rs1),
    .rs2_addr_i (in_rs2),
    .rs1_data_o (rs1_data),
    .rs2_data_o (rs2_data),
    .dbg_addr_i (rd_addr),
    .dbg_data_o (rd_data),
    .wb_en_i    (wb_en),
    .wb_addr_i  (rd_q),
    .wb_data_i  (alu_y),
    .ld_valid_i (ld_valid),
    .ld_addr_i  (ld_addr),
    .ld_data_i  (ld_data),
    .ld_ack_o   (ld_ack)
  );

`ifdef ALU_IMM_EN
  assign opb = in_use_imm ? in_imm : rs2_data;
`else
  assign opb = rs2_data;
`endif

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    wb_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        wb_en   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_q       <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_fs_q   <= '0;
      flag_reg_q <= '0;
      done_q     <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= wb_en;
      // Operands are captured from pre-edge RF contents; they then hold until the next accept.
      if (accept) begin
        rd_q     <= in_rd;
        alu_a_q  <= rs1_data;
        alu_b_q  <= opb;
        alu_fs_q <= in_fs;
      end
      if (wb_en) begin
        flag_reg_q <= alu_flag;
        retired_q  <= retired_q + CW'(1);
      end
    end
  end

  assign in_ready = (state_q == IDLE) && !rst;
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_fs   = alu_fs_q;
  assign flag_q   = flag_reg_q;
  assign done     = done_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a stub ALU; a second small-counter instance checks wrap.
module tb_alu_issue_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_fs, in_rd, in_rs1, in_rs2;
`ifdef ALU_IMM_EN
  logic [7:0]  in_imm;
  logic        in_use_imm;
`endif
  logic [7:0]  alu_a, alu_b, alu_y;
  logic [1:0]  alu_fs;
  logic [3:0]  alu_flag;
  logic        ld_valid, ld_ack;
  logic [1:0]  ld_addr, rd_addr;
  logic [7:0]  ld_data, rd_data;
  logic [3:0]  flag_q;
  logic        done;
  logic [15:0] retired;

  logic        wrap_valid;
  logic        w_in_ready, w_ld_ack, w_done;
  logic [7:0]  w_alu_a, w_alu_b, w_rd_data;
  logic [1:0]  w_alu_fs;
  logic [3:0]  w_flag_q;
  logic [2:0]  w_retired;

  int n_cmp = 0;
  int n_fail = 0;
  int exp_retired = 0;

  typedef struct {
    logic [1:0] fs, rd, rs1, rs2;
    logic [7:0] v1, v2, y;
    logic [3:0] flag;
  } vec_t;
  vec_t vecs[6];

  alu_issue_unit dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fs(in_fs), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
`ifdef ALU_IMM_EN
    .in_imm(in_imm), .in_use_imm(in_use_imm),
`endif
    .alu_a(alu_a), .alu_b(alu_b), .alu_fs(alu_fs),
    .alu_y(alu_y), .alu_flag(alu_flag),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .flag_q(flag_q), .done(done), .retired(retired)
  );

  alu_issue_unit #(.CW(3)) u_wrap (
    .clk(clk), .rst(rst),
    .in_valid(wrap_valid), .in_ready(w_in_ready),
    .in_fs(2'b00), .in_rd(2'b00), .in_rs1(2'b00), .in_rs2(2'b00),
`ifdef ALU_IMM_EN
    .in_imm(8'h00), .in_use_imm(1'b0),
`endif
    .alu_a(w_alu_a), .alu_b(w_alu_b), .alu_fs(w_alu_fs),
    .alu_y(8'h00), .alu_flag(4'h0),
    .ld_valid(1'b0), .ld_addr(2'b00), .ld_data(8'h00), .ld_ack(w_ld_ack),
    .rd_addr(2'b00), .rd_data(w_rd_data),
    .flag_q(w_flag_q), .done(w_done), .retired(w_retired)
  );

  // Stub ALU
  always_comb begin
    case (alu_fs)
      2'b00:   alu_y = alu_a + alu_b;
      2'b01:   alu_y = alu_a - alu_b;
      2'b10:   alu_y = alu_a | alu_b;
      default: alu_y = 8'h00;
    endcase
    alu_flag = {3'b000, alu_y == 8'h00};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_reg(input logic [1:0] a, input logic [7:0] d);
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    #1;
    check("ld_ack_idle", ld_ack, 1);
    @(posedge clk); #1;
    ld_valid = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [1:0] a, input logic [7:0] exp);
    rd_addr = a;
    #1;
    check(name, rd_data, exp);
  endtask

  task automatic issue(input logic [1:0] fs, rd, rs1, rs2,
                       input logic [7:0] exp_a, exp_b, exp_y, input logic [3:0] exp_flag);
    in_valid = 1'b1; in_fs = fs; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    #1;
    check("in_ready_idle", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("alu_a", alu_a, exp_a);
    check("alu_b", alu_b, exp_b);
    check("alu_fs", alu_fs, fs);
    check("in_ready_exec", in_ready, 0);
    check("done_exec", done, 0);
    @(posedge clk); #1;
    exp_retired++;
    check("done_pulse", done, 1);
    check("flag_q", flag_q, exp_flag);
    check("retired", retired, exp_retired);
    check("in_ready_after", in_ready, 1);
    read_check("rf_wb", rd, exp_y);
    @(posedge clk); #1;
    check("done_clear", done, 0);
  endtask

  initial begin
    vecs[0] = '{2'd2, 2'd3, 2'd1, 2'd2, 8'h02, 8'h01, 8'h03, 4'h0};
    vecs[1] = '{2'd1, 2'd1, 2'd1, 2'd2, 8'h12, 8'h12, 8'h00, 4'h1};
    vecs[2] = '{2'd0, 2'd2, 2'd0, 2'd2, 8'hFF, 8'h01, 8'h00, 4'h1};
    vecs[3] = '{2'd1, 2'd0, 2'd3, 2'd1, 8'h05, 8'h07, 8'hFE, 4'h0};
    vecs[4] = '{2'd0, 2'd3, 2'd2, 2'd2, 8'h40, 8'h40, 8'h80, 4'h0};
    vecs[5] = '{2'd2, 2'd2, 2'd0, 2'd3, 8'hA0, 8'h0C, 8'hAC, 4'h0};

    rst = 1'b1; in_valid = 1'b0; in_fs = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0; wrap_valid = 1'b0;
`ifdef ALU_IMM_EN
    in_imm = '0; in_use_imm = 1'b0;
`endif

    // Reset state
    #3;
    check("rst_in_ready", in_ready, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_fs", alu_fs, 0);
    check("rst_flag_q", flag_q, 0);
    check("rst_done", done, 0);
    check("rst_retired", retired, 0);
    for (int i = 0; i < 4; i++) read_check("rst_rf", 2'(i), 8'h00);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Table-driven instructions
    for (int i = 0; i < 6; i++) begin
      load_reg(vecs[i].rs1, vecs[i].v1);
      load_reg(vecs[i].rs2, vecs[i].v2);
      issue(vecs[i].fs, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
            vecs[i].v1, vecs[i].v2, vecs[i].y, vecs[i].flag);
    end

    // Load colliding with writeback is refused, then retried
    load_reg(2'd1, 8'h10);
    load_reg(2'd2, 8'h20);
    load_reg(2'd3, 8'h77);
    in_valid = 1'b1; in_fs = 2'b00; in_rd = 2'd3; in_rs1 = 2'd1; in_rs2 = 2'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    ld_valid = 1'b1; ld_addr = 2'd3; ld_data = 8'hAA;
    #1;
    check("ld_ack_conflict", ld_ack, 0);
    @(posedge clk); #1;
    exp_retired++;
    check("ld_ack_retry", ld_ack, 1);
    check("conflict_done", done, 1);
    read_check("conflict_wb_wins", 2'd3, 8'h30);
    @(posedge clk); #1;
    ld_valid = 1'b0;
    read_check("retry_load", 2'd3, 8'hAA);

    // Load to a different register during EXEC commits alongside writeback
    in_valid = 1'b1; in_fs = 2'b10; in_rd = 2'd3; in_rs1 = 2'd1; in_rs2 = 2'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    ld_valid = 1'b1; ld_addr = 2'd0; ld_data = 8'h5C;
    #1;
    check("ld_ack_no_conflict", ld_ack, 1);
    @(posedge clk); #1;
    exp_retired++;
    ld_valid = 1'b0;
    check("retired_parallel", retired, exp_retired);
    read_check("parallel_load", 2'd0, 8'h5C);
    read_check("parallel_wb", 2'd3, 8'h30);
    @(posedge clk); #1;

`ifdef ALU_IMM_EN
    // Immediate operand B
    load_reg(2'd1, 8'h23);
    load_reg(2'd2, 8'h55);
    in_use_imm = 1'b1; in_imm = 8'hFD;
    issue(2'b00, 2'd0, 2'd1, 2'd2, 8'h23, 8'hFD, 8'h20, 4'h0);
    in_use_imm = 1'b0;
`endif

    // Reset during EXEC discards the instruction
    load_reg(2'd1, 8'h09);
    in_valid = 1'b1; in_fs = 2'b00; in_rd = 2'd3; in_rs1 = 2'd1; in_rs2 = 2'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_done", done, 0);
    check("midrst_retired", retired, 0);
    read_check("midrst_rf1", 2'd1, 8'h00);
    @(posedge clk); #1;
    check("midrst_hold_in_ready", in_ready, 0);
    check("midrst_hold_done", done, 0);
    rst = 1'b0;
    exp_retired = 0;
    #1;
    check("midrst_release_in_ready", in_ready, 1);
    read_check("midrst_no_wb", 2'd3, 8'h00);
    @(posedge clk); #1;
    check("midrst_no_done", done, 0);
    check("midrst_retired_after", retired, 0);

    // Back-to-back: in_valid held high on both instances
    in_valid = 1'b1; in_fs = 2'b00; in_rd = 2'd0; in_rs1 = 2'd0; in_rs2 = 2'd0;
    wrap_valid = 1'b1;
    for (int i = 0; i < 18; i++) begin
      check("b2b_in_ready", in_ready, ((i % 2) == 0) ? 1 : 0);
      check("b2b_done", done, (((i % 2) == 0) && (i >= 2)) ? 1 : 0);
      check("b2b_retired", retired, i / 2);
      check("wrap_retired", w_retired, (i / 2) % 8);
      check("wrap_done", w_done, (((i % 2) == 0) && (i >= 2)) ? 1 : 0);
      check("wrap_in_ready", w_in_ready, ((i % 2) == 0) ? 1 : 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wrap_valid = 1'b0;
    check("wrap_alu_a", w_alu_a, 0);
    check("wrap_alu_b", w_alu_b, 0);
    check("wrap_alu_fs", w_alu_fs, 0);
    check("wrap_flag_q", w_flag_q, 0);
    check("wrap_ld_ack", w_ld_ack, 0);
    check("wrap_rd_data", w_rd_data, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
